// File: rtl/prog_clock_divider_if.sv
// Load port of the programmable clock divider: a valid/ready request carrying
// the target channel and new divisor/high-time, plus the registered error pulse.
interface prog_clock_divider_if #(
    parameter int WIDTH = 28,
    parameter int CH_W  = 1
);
    logic             load_valid;
    logic [CH_W-1:0]  load_ch;
    logic [WIDTH-1:0] load_div;
    logic [WIDTH-1:0] load_high;
    logic             load_ready;
    logic             load_err;

    modport master (
        output load_valid, load_ch, load_div, load_high,
        input  load_ready, load_err
    );

    modport slave (
        input  load_valid, load_ch, load_div, load_high,
        output load_ready, load_err
    );
endinterface

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider. Each channel produces a divided
// clock-enable waveform (low phase first, then high) and an end-of-period tick.
// New settings are staged in a pending slot and only applied at a period
// boundary (or while the channel is disabled), so outputs never show runts.
module prog_clock_divider #(
    parameter int WIDTH       = 28,
    parameter int CHANNELS    = 2,
    parameter int CH_W        = 1,
    parameter int DEFAULT_DIV = 10_000_000
) (
    input  logic                clock_in,
    input  logic                reset,
    input  logic [CHANNELS-1:0] enable,
    prog_clock_divider_if.slave ld,
    output logic [CHANNELS-1:0] clock_out,
    output logic [CHANNELS-1:0] tick
);
    localparam logic [WIDTH-1:0] DEF_DIV  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DEF_HIGH = WIDTH'(DEFAULT_DIV / 2);

    logic [CHANNELS-1:0][WIDTH-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0][WIDTH-1:0] div_q, div_d;
    logic [CHANNELS-1:0][WIDTH-1:0] high_q, high_d;
    logic [CHANNELS-1:0][WIDTH-1:0] pdiv_q, pdiv_d;
    logic [CHANNELS-1:0][WIDTH-1:0] phigh_q, phigh_d;
    logic [CHANNELS-1:0]            pend_q, pend_d;
    logic [CHANNELS-1:0]            clk_q, clk_d;
    logic [CHANNELS-1:0]            tick_q, tick_d;
    logic [CHANNELS-1:0]            wrap;
    logic                           err_q, err_d;
    logic                           ready;
    logic                           vals_ok;
    logic                           xfer;

    // Ready reflects the addressed channel's pending slot; out-of-range channels are never ready.
    always_comb begin
        ready = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ld.load_ch == CH_W'(i)) ready = ~pend_q[i];
        end
    end

    // high <= div-1 is written as high < div so no subtraction can wrap.
    assign vals_ok = (ld.load_div >= WIDTH'(2)) && (ld.load_high != '0) &&
                     (ld.load_high < ld.load_div);
    assign xfer    = ld.load_valid & ready;
    assign err_d   = xfer & ~vals_ok;

    // Last count of the current period, per channel.
    always_comb begin
        wrap = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wrap[i] = (cnt_q[i] == div_q[i] - WIDTH'(1));
        end
    end

    // Per-channel counting, output decode, pending apply and load capture.
    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        high_d  = high_q;
        pdiv_d  = pdiv_q;
        phigh_d = phigh_q;
        pend_d  = pend_q;
        clk_d   = '0;
        tick_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (enable[i]) begin
                // Compare against the pre-edge count: output lags the counter by one cycle.
                clk_d[i]  = (cnt_q[i] >= (div_q[i] - high_q[i]));
                tick_d[i] = wrap[i];
                cnt_d[i]  = wrap[i] ? '0 : cnt_q[i] + WIDTH'(1);
            end else begin
                cnt_d[i] = '0;
            end
            // Uses pend_q, so a load accepted on a wrap edge waits for the next wrap.
            if (pend_q[i] && (!enable[i] || wrap[i])) begin
                div_d[i]  = pdiv_q[i];
                high_d[i] = phigh_q[i];
                pend_d[i] = 1'b0;
            end
            if (xfer && vals_ok && (ld.load_ch == CH_W'(i))) begin
                pdiv_d[i]  = ld.load_div;
                phigh_d[i] = ld.load_high;
                pend_d[i]  = 1'b1;
            end
        end
    end

    // State registers; reset wins over any load or pending setting.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            cnt_q   <= '0;
            div_q   <= {CHANNELS{DEF_DIV}};
            high_q  <= {CHANNELS{DEF_HIGH}};
            pdiv_q  <= '0;
            phigh_q <= '0;
            pend_q  <= '0;
            clk_q   <= '0;
            tick_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            high_q  <= high_d;
            pdiv_q  <= pdiv_d;
            phigh_q <= phigh_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
        end
    end

    assign ld.load_ready = ready;
    assign ld.load_err   = err_q;
    assign clock_out     = clk_q;
    assign tick          = tick_q;
endmodule

// File: tb/tb_prog_clock_divider.sv
// Bench for prog_clock_divider: directed load/enable/reset sequence. Expected
// per-cycle output values are queued up front; a negedge monitor pops and
// compares the entries due in each cycle.
module tb_prog_clock_divider;
    localparam int WIDTH = 8;
    localparam int CHANNELS = 2;
    localparam int CH_W = 2;
    localparam int DEFAULT_DIV = 10;

    logic                clk;
    logic                reset;
    logic [CHANNELS-1:0] enable;
    logic [CHANNELS-1:0] clock_out;
    logic [CHANNELS-1:0] tick;
    int                  cyc;
    int                  checks;
    int                  errors;

    prog_clock_divider_if #(.WIDTH(WIDTH), .CH_W(CH_W)) lif ();

    prog_clock_divider #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .CH_W(CH_W), .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clock_in (clk),
        .reset    (reset),
        .enable   (enable),
        .ld       (lif),
        .clock_out(clock_out),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // sig: 0 clock_out, 1 tick, 2 load_ready, 3 load_err
    typedef struct {
        int   cyc;
        int   sig;
        int   ch;
        logic exp;
    } exp_t;
    exp_t q[$];

    task automatic push(input int c, input int s, input int ch, input logic e);
        exp_t x;
        x.cyc = c; x.sig = s; x.ch = ch; x.exp = e;
        q.push_back(x);
    endtask

    // Waveform of a period: (div-high) low cycles, then high cycles, tick on the last one.
    task automatic expect_wave(input int ch, input int start, input int div,
                               input int high, input int n);
        for (int j = 0; j < n; j++) begin
            int ph;
            ph = j % div;
            push(start + j, 0, ch, (ph >= div - high));
            push(start + j, 1, ch, (ph == div - 1));
        end
    endtask

    task automatic expect_zero(input int ch, input int c);
        push(c, 0, ch, 1'b0);
        push(c, 1, ch, 1'b0);
    endtask

    task automatic go(input int n);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < n);
    endtask

    task automatic load(input int ch, input int dv, input int hi, input logic v);
        lif.load_ch    = CH_W'(ch);
        lif.load_div   = WIDTH'(dv);
        lif.load_high  = WIDTH'(hi);
        lif.load_valid = v;
    endtask

    // Monitor: compare every entry due in the current cycle, then drop it.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                logic  act;
                string nm;
                case (q[i].sig)
                    0:       begin act = clock_out[q[i].ch]; nm = "clock_out"; end
                    1:       begin act = tick[q[i].ch];      nm = "tick"; end
                    2:       begin act = lif.load_ready;     nm = "load_ready"; end
                    default: begin act = lif.load_err;       nm = "load_err"; end
                endcase
                checks++;
                if (act !== q[i].exp) begin
                    errors++;
                    $display("FAIL %s ch%0d cyc %0d: got %b expected %b",
                             nm, q[i].ch, cyc, act, q[i].exp);
                end
                q.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d expected below 200", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        enable = 2'b11;
        load(0, 0, 0, 1'b0);

        // Reset state.
        for (int c = 1; c <= 2; c++) begin
            expect_zero(0, c);
            expect_zero(1, c);
        end
        // Channel 0 history: default, reload to 4/1, load 5/2 at a wrap,
        // partial period before disable, disabled, fresh 3/1 period, reset, default.
        expect_wave(0, 3, 10, 5, 30);
        expect_wave(0, 33, 4, 1, 20);
        expect_wave(0, 53, 5, 2, 19);
        for (int c = 72; c <= 74; c++) expect_zero(0, c);
        expect_wave(0, 75, 3, 1, 15);
        expect_zero(0, 90);
        expect_wave(0, 91, 10, 5, 20);
        // Channel 1 stays on the default until reset.
        expect_wave(1, 3, 10, 5, 87);
        expect_zero(1, 90);
        expect_wave(1, 91, 10, 5, 20);
        // load_err: one pulse per invalid handshake.
        for (int c = 1; c <= 112; c++) push(c, 3, 0, (c == 35 || c == 37 || c == 39));
        // load_ready.
        push(2, 2, 0, 1'b1);
        push(25, 2, 0, 1'b1);
        for (int c = 26; c <= 31; c++) push(c, 2, 0, 1'b0);
        for (int c = 32; c <= 47; c++) push(c, 2, 0, 1'b1);
        for (int c = 48; c <= 51; c++) push(c, 2, 0, 1'b0);
        push(52, 2, 0, 1'b1);
        push(69, 2, 0, 1'b1);
        push(70, 2, 0, 1'b0);
        push(71, 2, 0, 1'b0);
        push(72, 2, 0, 1'b1);
        push(88, 2, 0, 1'b0);
        push(89, 2, 0, 1'b0);
        push(90, 2, 0, 1'b1);
        push(110, 2, 0, 1'b0);
        push(111, 2, 0, 1'b0);
        push(112, 2, 0, 1'b1);

        go(2);  reset = 1'b0;
        // Mid-period reload of ch0 at counter 3.
        go(25); load(0, 4, 1, 1'b1);
        go(26); lif.load_valid = 1'b0;
        // Invalid loads.
        go(34); load(0, 1, 0, 1'b1);
        go(35); lif.load_valid = 1'b0;
        go(36); load(0, 6, 6, 1'b1);
        go(37); lif.load_valid = 1'b0;
        go(38); load(0, 6, 0, 1'b1);
        go(39); lif.load_valid = 1'b0;
        // Odd divisor accepted on a wrap edge.
        go(47); load(0, 5, 2, 1'b1);
        go(48); lif.load_valid = 1'b0;
        // Pending load, then drop enable mid-high-phase.
        go(69); load(0, 3, 1, 1'b1);
        go(70); lif.load_valid = 1'b0;
        go(71); enable = 2'b10;
        go(74); enable = 2'b11;
        // ch1 pending load wiped by reset.
        go(87); load(1, 3, 1, 1'b1);
        go(88); lif.load_valid = 1'b0;
        go(89); reset = 1'b1;
        go(90); reset = 1'b0;
        // Out-of-range channel is never ready and never errors.
        go(110); load(2, 1, 0, 1'b1);
        go(111); load(3, 4, 1, 1'b0);
        go(112); load(0, 0, 0, 1'b0);
        go(113);

        if (q.size() != 0) begin
            errors += q.size();
            $display("FAIL scoreboard_drain: got %0d unchecked entries expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
